// File: rtl/seq_mul_pkg.sv
// Shared constants and FSM encodings for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mul_pkg;

   localparam int WIDTH = 32;   // operand width
   localparam int KEY_W = 125;  // locking key width
   localparam int CNT_W = 5;    // RUN-cycle counter width

   // One-hot FSM states
   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_RUN  = 3'b010,
      S_DONE = 3'b100
   } state_t;

endpackage

// File: rtl/seq_mul_if.sv
// Start/done handshake bundle between a caller and seq_mul_core.
// Latency: n/a (wiring only).
// Backpressure: none; the caller holds ap_start until it sees ap_ready.
// Ports: ap_start, a, b, working_key (caller -> core); ap_done, ap_ready,
//        ap_idle, ap_return (core -> caller).
interface seq_mul_if #(
   parameter int WIDTH = seq_mul_pkg::WIDTH,
   parameter int KEY_W = seq_mul_pkg::KEY_W
);
   logic                 ap_start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [KEY_W-1:0]     working_key;
   logic                 ap_done;
   logic                 ap_ready;
   logic                 ap_idle;
   logic [2*WIDTH-1:0]   ap_return;

   modport master (
      output ap_start, a, b, working_key,
      input  ap_done, ap_ready, ap_idle, ap_return
   );

   modport slave (
      input  ap_start, a, b, working_key,
      output ap_done, ap_ready, ap_idle, ap_return
   );
endinterface

// File: rtl/seq_mul_dp.sv
// Shift-add datapath: operand registers plus 2*WIDTH accumulator.
// Latency: one shift-add step per cycle while step is high.
// Backpressure: none; sequenced entirely by the FSM strobes.
// Ports: ap_clk/ap_rst; load (latch a,b, clear acc), step (one shift-add),
//        clear (zero everything); acc_next = accumulator after this step's add.
module seq_mul_dp #(
   parameter int WIDTH = seq_mul_pkg::WIDTH
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic                 load,
   input  logic                 step,
   input  logic                 clear,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   acc_next
);
   import seq_mul_pkg::*;

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplr;

   // Exposed combinationally so the FSM can capture the final step's sum
   // in the same edge that leaves RUN.
   assign acc_next = mplr[0] ? (acc + mcand) : acc;

   always_ff @(posedge ap_clk) begin
      if (ap_rst || clear) begin
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
      end else if (load) begin
         mcand <= {{WIDTH{1'b0}}, a};
         mplr  <= b;
         acc   <= '0;
      end else if (step) begin
         acc   <= acc_next;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
      end
   end
endmodule

// File: rtl/seq_mul_core.sv
// Sequential unsigned multiplier, one multiplier bit per cycle, with key lock.
// Latency: start accepted in cycle 0, ap_done/ap_ready in cycle WIDTH+1.
// Backpressure: ap_start is only sampled in IDLE; held high it re-arms back-to-back.
// Ports: ap_clk, ap_rst (sync, active high); bus = seq_mul_if slave
//        (ap_start/a/b/working_key in, ap_done/ap_ready/ap_idle/ap_return out).
module seq_mul_core #(
   parameter int WIDTH = seq_mul_pkg::WIDTH,
   parameter int KEY_W = seq_mul_pkg::KEY_W
) (
   input  logic     ap_clk,
   input  logic     ap_rst,
   seq_mul_if.slave bus
);
   import seq_mul_pkg::*;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] ret_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] inv_mask;
   logic               accept;
   logic               lock0;
   logic               lock1;
   logic               last;
   logic               dp_load;
   logic               dp_step;
   logic               dp_clear;
   logic               unused_key;

   // Only the low three key bits steer behaviour.
   assign unused_key = ^bus.working_key[KEY_W-1:3];

   assign accept   = (state == S_IDLE) && bus.ap_start;
   assign lock0    = bus.working_key[0] && (bus.a[1:0] == 2'b01);
   assign lock1    = bus.working_key[1] && (cnt[1:0] == 2'b01);
   assign last     = (cnt == CNT_W'(WIDTH - 1));
   assign inv_mask = {{(2*WIDTH-1){1'b0}}, bus.working_key[2]};

   // Branch-0 acceptance skips RUN, so the datapath is just zeroed.
   assign dp_load  = accept && !lock0;
   assign dp_clear = accept && lock0;
   assign dp_step  = (state == S_RUN);

   assign bus.ap_done   = (state == S_DONE);
   assign bus.ap_ready  = (state == S_DONE);
   assign bus.ap_idle   = (state == S_IDLE) && !bus.ap_start;
   assign bus.ap_return = ret_q;

   seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .load     (dp_load),
      .step     (dp_step),
      .clear    (dp_clear),
      .a        (bus.a),
      .b        (bus.b),
      .acc_next (acc_next)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         ret_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.ap_start) begin
                  cnt <= '0;
                  if (lock0) begin
                     state <= S_DONE;
                     ret_q <= inv_mask;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               cnt <= cnt + 1'b1;
               // acc_next already includes this cycle's partial product.
               if (last || lock1) begin
                  state <= S_DONE;
                  ret_q <= acc_next ^ inv_mask;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mul_core.sv
// Self-checking bench for seq_mul_core: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_mul_core;
   logic ap_clk = 1'b0;
   logic ap_rst;
   int   n_cmp = 0;
   int   n_err = 0;

   seq_mul_if #(.WIDTH(32), .KEY_W(125)) bus ();

   seq_mul_core #(.WIDTH(32), .KEY_W(125)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
   );

   always #5 ap_clk = ~ap_clk;

   // Advance one cycle; inputs are driven and outputs sampled 1 time unit
   // after the rising edge.
   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: result and cycle of ap_done (acceptance = cycle 0).
   function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic [124:0] key,
                                 output logic [63:0] r, output int lat);
      if (key[0] && ia[1:0] == 2'b01) begin
         r   = 64'd0;
         lat = 1;
      end else if (key[1]) begin
         // early exit after the second RUN cycle: only b[1:0] contributed
         r   = 64'(ia) * 64'(ib % 32'd4);
         lat = 3;
      end else begin
         r   = 64'(ia) * 64'(ib);
         lat = 33;
      end
      r[0] = r[0] ^ key[2];
   endfunction

   // One start pulse; optionally scrambles ap_start/a/b while busy.
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [124:0] key, input bit jitter, input string tag);
      logic [63:0] exp_ret;
      logic [63:0] got;
      int          exp_lat;
      int          lat;
      logic        rdy;
      model(ia, ib, key, exp_ret, exp_lat);
      bus.a = ia;
      bus.b = ib;
      bus.working_key = key;
      bus.ap_start = 1'b1;
      lat = -1;
      got = '0;
      rdy = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         bus.ap_start = 1'b0;
         if (jitter) begin
            bus.a = $urandom;
            bus.b = $urandom;
            bus.ap_start = 1'($urandom_range(0, 1));
         end
         if (bus.ap_done) begin
            lat = k;
            got = bus.ap_return;
            rdy = bus.ap_ready;
            bus.ap_start = 1'b0;
            break;
         end
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_return"}, got, exp_ret);
      chk({tag, "_ready"}, 64'(rdy), 64'd1);
      tick();
      chk({tag, "_done_pulse"}, 64'(bus.ap_done), 64'd0);
      chk({tag, "_idle_after"}, 64'(bus.ap_idle), 64'd1);
      chk({tag, "_hold"}, bus.ap_return, exp_ret);
   endtask

   initial begin
      logic [124:0] key;
      int           dq[$];
      logic [63:0]  rq[$];
      bit           seen;
      int           d0, d1;
      logic [63:0]  r0, r1;

      // ---- reset state ----
      ap_rst = 1'b1;
      bus.ap_start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.working_key = '0;
      tick();
      tick();
      chk("rst_done", 64'(bus.ap_done), 64'd0);
      chk("rst_ready", 64'(bus.ap_ready), 64'd0);
      chk("rst_idle", 64'(bus.ap_idle), 64'd1);
      chk("rst_return", bus.ap_return, 64'd0);
      bus.ap_start = 1'b1;
      #1;
      chk("rst_idle_start_hi", 64'(bus.ap_idle), 64'd0);
      bus.ap_start = 1'b0;
      ap_rst = 1'b0;
      tick();

      // ---- directed cases ----
      run_op(32'd3, 32'd5, 125'd0, 1'b0, "basic_3x5");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 125'd0, 1'b0, "max_operands");
      run_op(32'd1, 32'd7, 125'h1, 1'b0, "lock0");
      run_op(32'd1, 32'd7, 125'd0, 1'b0, "lock0_nokey");
      run_op(32'd2, 32'd2, 125'h4, 1'b0, "lock2_invert");
      run_op(32'd10, 32'd7, 125'h2, 1'b0, "lock1_early");
      key = '0;
      key[124:3] = {122{1'b1}};
      run_op(32'd1234, 32'd5678, key, 1'b0, "upper_key_bits");

      // ---- reset mid-RUN ----
      run_op(32'd3, 32'd5, 125'd0, 1'b0, "pre_reset");
      bus.a = 32'd9;
      bus.b = 32'd9;
      bus.working_key = '0;
      bus.ap_start = 1'b1;
      seen = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         bus.ap_start = 1'b0;
         if (bus.ap_done) seen = 1'b1;
      end
      ap_rst = 1'b1;
      tick();
      chk("midrst_idle", 64'(bus.ap_idle), 64'd1);
      chk("midrst_return", bus.ap_return, 64'd0);
      chk("midrst_done", 64'(bus.ap_done), 64'd0);
      ap_rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.ap_done) seen = 1'b1;
      end
      chk("midrst_no_done", 64'(seen), 64'd0);
      run_op(32'd9, 32'd9, 125'd0, 1'b0, "restart_9x9");

      // ---- back-to-back with start held high ----
      bus.a = 32'd2;
      bus.b = 32'd3;
      bus.working_key = '0;
      bus.ap_start = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (k == 5) begin
            bus.a = 32'd4;
            bus.b = 32'd4;
         end
         if (k == 35) bus.ap_start = 1'b0;
         if (bus.ap_done) begin
            dq.push_back(k);
            rq.push_back(bus.ap_return);
         end
      end
      d0 = (dq.size() > 0) ? dq[0] : -1;
      d1 = (dq.size() > 1) ? dq[1] : -1;
      r0 = (rq.size() > 0) ? rq[0] : 64'hDEAD;
      r1 = (rq.size() > 1) ? rq[1] : 64'hDEAD;
      chk("b2b_count", 64'(dq.size()), 64'd2);
      chk("b2b_first_cycle", 64'(d0), 64'd33);
      chk("b2b_first_return", r0, 64'd6);
      chk("b2b_second_cycle", 64'(d1), 64'd67);
      chk("b2b_second_return", r1, 64'd16);
      tick();

      // ---- randomized operations against the model ----
      for (int i = 0; i < 40; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         key[2:0] = 3'($urandom_range(0, 7));
         run_op($urandom, $urandom, key, 1'b1, $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
